// File: rtl/styler_host.sv
// Host-side bus initiator for the styler tile: writes one styling job through the tile's
// register port (skipping bytes a shadow copy says are unchanged) and reads the result back.
module styler_host #(
    parameter int unsigned READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_scanline,
    input  logic [5:0]  req_ctrl,
    input  logic [15:0] req_bitmap,
    input  logic [24:0] req_attr,
    input  logic [2:0]  req_phase,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_scanline,
    output logic [15:0] rsp_bitmap,
    output logic [7:0]  bus_ui,
    output logic [7:0]  bus_uio_out,
    output logic [7:0]  bus_uio_oe,
    input  logic [7:0]  bus_uo
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

    localparam logic [3:0] LastWait = 4'(READ_WAIT - 1);

    function automatic logic [7:0] entry_byte(input logic [2:0]  idx,
                                              input logic [3:0]  scan,
                                              input logic [5:0]  ctrl,
                                              input logic [15:0] bitmap,
                                              input logic [24:0] attr);
        case (idx)
            3'd0:    entry_byte = {4'b0, scan};
            3'd1:    entry_byte = {2'b0, ctrl};
            3'd2:    entry_byte = bitmap[7:0];
            3'd3:    entry_byte = bitmap[15:8];
            3'd4:    entry_byte = attr[7:0];
            3'd5:    entry_byte = attr[15:8];
            3'd6:    entry_byte = attr[23:16];
            default: entry_byte = {7'b0, attr[24]};
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  scan_q;
    logic [5:0]  ctrl_q;
    logic [15:0] bitmap_q;
    logic [24:0] attr_q;
    logic [2:0]  phase_q;
    logic [7:0]  dirty_q;
    logic [7:0]  shadow_q [8];
    logic        shadow_valid_q;
    logic        job_flushed_q;
    logic [1:0]  rd_idx_q;
    logic [3:0]  wait_q;
    logic [3:0]  rsp_scan_q;
    logic [15:0] rsp_bitmap_q;

    logic        accept;
    logic [7:0]  acc_mask;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_onehot;
    logic [7:0]  dirty_rest;
    logic        last_write;
    logic [7:0]  wr_byte;
    logic [2:0]  rd_addr;
    logic        rd_last;

    assign accept     = req_valid & (state_q == StIdle);
    assign wr_onehot  = 8'b1 << wr_addr;
    assign dirty_rest = dirty_q & ~wr_onehot;
    assign last_write = (dirty_rest == 8'b0);
    assign wr_byte    = entry_byte(wr_addr, scan_q, ctrl_q, bitmap_q, attr_q);
    assign rd_last    = (wait_q == LastWait);

    // A flush or an invalid shadow marks every entry dirty.
    always_comb begin
        acc_mask = '0;
        for (int i = 0; i < 8; i++) begin
            acc_mask[i] = flush | ~shadow_valid_q |
                (entry_byte(3'(i), req_scanline, req_ctrl, req_bitmap, req_attr) != shadow_q[i]);
        end
    end

    // Lowest dirty address goes first.
    always_comb begin
        wr_addr = '0;
        for (int i = 7; i >= 0; i--) begin
            if (dirty_q[i]) wr_addr = 3'(i);
        end
    end

    always_comb begin
        case (rd_idx_q)
            2'd0:    rd_addr = 3'd0;
            2'd1:    rd_addr = 3'd2;
            default: rd_addr = 3'd3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = (acc_mask == 8'b0) ? StRead : StWrite;
            StWrite: if (last_write) state_d = StRead;
            StRead:  if (rd_last && rd_idx_q == 2'd2) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q         <= '0;
            ctrl_q         <= '0;
            bitmap_q       <= '0;
            attr_q         <= '0;
            phase_q        <= '0;
            dirty_q        <= '0;
            for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
            shadow_valid_q <= 1'b0;
            job_flushed_q  <= 1'b0;
            rd_idx_q       <= '0;
            wait_q         <= '0;
            rsp_scan_q     <= '0;
            rsp_bitmap_q   <= '0;
        end else begin
            if (accept) begin
                scan_q        <= req_scanline;
                ctrl_q        <= req_ctrl;
                bitmap_q      <= req_bitmap;
                attr_q        <= req_attr;
                phase_q       <= req_phase;
                dirty_q       <= acc_mask;
                job_flushed_q <= 1'b0;
                rd_idx_q      <= '0;
                wait_q        <= '0;
            end

            if (state_q == StWrite) begin
                dirty_q           <= dirty_rest;
                shadow_q[wr_addr] <= wr_byte;
                if (flush) job_flushed_q <= 1'b1;
            end

            if (state_q == StRead) begin
                if (rd_last) begin
                    wait_q   <= '0;
                    rd_idx_q <= rd_idx_q + 2'd1;
                    case (rd_idx_q)
                        2'd0:    rsp_scan_q         <= bus_uo[3:0];
                        2'd1:    rsp_bitmap_q[7:0]  <= bus_uo;
                        default: rsp_bitmap_q[15:8] <= bus_uo;
                    endcase
                end else begin
                    wait_q <= wait_q + 4'd1;
                end
            end

            // A flush seen anywhere during the job keeps the shadow invalid afterwards.
            if (flush) begin
                shadow_valid_q <= 1'b0;
            end else if (state_q == StWrite && last_write && !job_flushed_q) begin
                shadow_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus_ui      = {1'b1, 1'b1, phase_q, 3'b0};
        bus_uio_out = '0;
        bus_uio_oe  = '0;
        case (state_q)
            StWrite: begin
                bus_ui      = {1'b0, 1'b1, phase_q, wr_addr};
                bus_uio_out = wr_byte;
                bus_uio_oe  = 8'hFF;
            end
            StRead:  bus_ui = {1'b1, 1'b1, phase_q, rd_addr};
            default: ;
        endcase
    end

    assign req_ready    = (state_q == StIdle);
    assign rsp_valid    = (state_q == StResp);
    assign rsp_scanline = rsp_scan_q;
    assign rsp_bitmap   = rsp_bitmap_q;

endmodule

// File: tb/tb_styler_host.sv
// Randomised bench for styler_host: a tile model answers reads, a job-level reference
// model predicts the write list, latency and read-back values.
module tb_styler_host;

    localparam int unsigned RW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_scanline = '0;
    logic [5:0]  req_ctrl = '0;
    logic [15:0] req_bitmap = '0;
    logic [24:0] req_attr = '0;
    logic [2:0]  req_phase = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_scanline;
    logic [15:0] rsp_bitmap;
    logic [7:0]  bus_ui;
    logic [7:0]  bus_uio_out;
    logic [7:0]  bus_uio_oe;
    logic [7:0]  bus_uo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    styler_host #(.READ_WAIT(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_scanline (req_scanline),
        .req_ctrl     (req_ctrl),
        .req_bitmap   (req_bitmap),
        .req_attr     (req_attr),
        .req_phase    (req_phase),
        .flush        (flush),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_scanline (rsp_scanline),
        .rsp_bitmap   (rsp_bitmap),
        .bus_ui       (bus_ui),
        .bus_uio_out  (bus_uio_out),
        .bus_uio_oe   (bus_uio_oe),
        .bus_uo       (bus_uo)
    );

    // Tile model: registers written on strobe-low edges; styled read-back is XOR 66 for the
    // bitmap bytes and the scanline nibble for address 0.
    logic [7:0] tile_reg [8];

    always @(posedge clk) begin
        if (bus_ui[7] == 1'b0) tile_reg[bus_ui[2:0]] <= bus_uio_out;
    end

    always_comb begin
        if (bus_ui[2:0] == 3'd0) bus_uo = {4'h0, tile_reg[0][3:0]};
        else                     bus_uo = tile_reg[bus_ui[2:0]] ^ 8'h66;
    end

    // Reference model of the host's shadow registers.
    logic [7:0] m_shadow [8];
    bit         m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ui"}, bus_ui, 8'hC0);
        check({tag, "_oe"}, bus_uio_oe, 8'h00);
        check({tag, "_uio"}, bus_uio_out, 8'h00);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
    endtask

    task automatic drive_accept(input logic [3:0] s, input logic [5:0] c, input logic [15:0] b,
                                input logic [24:0] a, input logic [2:0] ph, input bit fl);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid    = 1'b1;
        req_scanline = s;
        req_ctrl     = c;
        req_bitmap   = b;
        req_attr     = a;
        req_phase    = ph;
        flush        = fl;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        flush        = 1'b0;
        // Scramble the request fields to catch anything not latched at accept.
        req_scanline = 4'($urandom);
        req_ctrl     = 6'($urandom);
        req_bitmap   = 16'($urandom);
        req_attr     = 25'($urandom);
        req_phase    = 3'($urandom);
    endtask

    task automatic run_job(input logic [3:0] s, input logic [5:0] c, input logic [15:0] b,
                           input logic [24:0] a, input logic [2:0] ph, input bit fl,
                           input int hold, output int lat, output int nwr);
        logic [63:0] img;
        logic [10:0] expq [$];
        logic [10:0] e;
        int d;
        int cyc;
        int w;
        bit done;

        img = {7'b0, a[24], a[23:0], b, 2'b0, c, 4'b0, s};
        d = 0;
        for (int i = 0; i < 8; i++) begin
            if (fl || !m_valid || img[i*8 +: 8] != m_shadow[i]) begin
                expq.push_back({3'(i), img[i*8 +: 8]});
                d++;
            end
        end

        drive_accept(s, c, b, a, ph, fl);

        cyc  = 0;
        w    = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (!bus_ui[7]) begin
                    w++;
                    check("wr_oe", bus_uio_oe, 8'hFF);
                    check("wr_tri_phase", bus_ui[6:3], {1'b1, ph});
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check("wr_addr_data", {bus_ui[2:0], bus_uio_out}, e);
                    end
                end else begin
                    check("rd_oe", bus_uio_oe, 8'h00);
                end
            end
        end
        check("rsp_seen", done, 1);
        check("latency", cyc, d + 3 * RW);
        check("wr_count", w, d);
        check("rsp_scanline", rsp_scanline, s);
        check("rsp_bitmap", rsp_bitmap, b ^ 16'h6666);

        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_scanline", rsp_scanline, s);
            check("bp_bitmap", rsp_bitmap, b ^ 16'h6666);
            check("bp_no_strobe", bus_ui[7], 1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_dropped", rsp_valid, 0);
        check("req_ready_back", req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            if (fl || !m_valid || img[i*8 +: 8] != m_shadow[i]) m_shadow[i] = img[i*8 +: 8];
        end
        m_valid = 1'b1;
        lat = cyc;
        nwr = w;
    endtask

    initial begin
        int lat;
        int nwr;
        logic [3:0]  s;
        logic [5:0]  c;
        logic [15:0] b;
        logic [24:0] a;

        // Reset asserted between edges must take effect without a clock.
        #13;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        check("por_rsp_scanline", rsp_scanline, 4'h0);
        check("por_rsp_bitmap", rsp_bitmap, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0;

        run_job(4'h5, 6'h3C, 16'hA55A, 25'h1ABCDEF, 3'b101, 1'b0, 0, lat, nwr);
        check("first_lat", lat, 14);
        check("first_writes", nwr, 8);

        run_job(4'h5, 6'h3C, 16'hA55A, 25'h1ABCDEF, 3'b101, 1'b0, 0, lat, nwr);
        check("identical_lat", lat, 6);
        check("identical_writes", nwr, 0);

        run_job(4'h5, 6'h3C, 16'h775A, 25'h1ABCDEF, 3'b010, 1'b0, 0, lat, nwr);
        check("single_lat", lat, 7);
        check("single_writes", nwr, 1);

        run_job(4'h5, 6'h3C, 16'h775A, 25'h1ABCDEF, 3'b010, 1'b1, 0, lat, nwr);
        check("flush_writes", nwr, 8);
        run_job(4'h5, 6'h3C, 16'h775A, 25'h1ABCDEF, 3'b010, 1'b0, 0, lat, nwr);
        check("after_flush_writes", nwr, 0);

        run_job(4'h5, 6'h3C, 16'h775A, 25'h1ABCDEF, 3'b111, 1'b0, 5, lat, nwr);
        check("backpressure_lat", lat, 6);

        // Reset during the 4th write cycle of an all-dirty job.
        drive_accept(4'h9, 6'h11, 16'h1234, 25'h0456789, 3'b011, 1'b1);
        repeat (4) @(negedge clk);
        check("mid_write_strobe", bus_ui[7], 0);
        check("mid_write_addr", bus_ui[2:0], 3);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0;
        run_job(4'h9, 6'h11, 16'h1234, 25'h0456789, 3'b011, 1'b0, 0, lat, nwr);
        check("replay_writes", nwr, 8);

        s = 4'h9;
        c = 6'h11;
        b = 16'h1234;
        a = 25'h0456789;
        for (int j = 0; j < 25; j++) begin
            if ($urandom_range(0, 2) == 0) s = 4'($urandom);
            if ($urandom_range(0, 2) == 0) c = 6'($urandom);
            if ($urandom_range(0, 2) == 0) b[7:0] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) b[15:8] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = 25'($urandom);
            if ($urandom_range(0, 3) == 0) a[24] = ~a[24];
            run_job(s, c, b, a, 3'($urandom), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), lat, nwr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
